// File: rtl/input_arbiter_if.sv
// input_arbiter_if
//   Bundles the requester handshake and the sequential-source strobes used by
//   input_arbiter.
//   master modport: the arbiter side (drives ack/rd_*/busy/src_*/words_consumed).
//   slave modport : the requester/source side (drives req, rewind, src_data).
//   Signals:
//     req[NUM_REQ]     per-requester word request, held until ack
//     rewind           one-cycle pulse restarting the stream at word 0
//     ack[NUM_REQ]     one-hot one-cycle grant pulse, rd_data/rd_eof valid with it
//     rd_data          delivered word
//     rd_eof           high with ack when the stream is exhausted
//     busy             arbiter not idle or a rewind is pending
//     src_read         read strobe to the source
//     src_reset        address-reset strobe to the source
//     src_data         source data, valid the cycle after src_read
//     words_consumed   words read since reset/rewind, saturating at 2**ADDR_W
interface input_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0] req;
  logic               rewind;
  logic [NUM_REQ-1:0] ack;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_eof;
  logic               busy;
  logic               src_read;
  logic               src_reset;
  logic [DATA_W-1:0]  src_data;
  logic [ADDR_W:0]    words_consumed;

  modport master (
    input  req, rewind, src_data,
    output ack, rd_data, rd_eof, busy, src_read, src_reset, words_consumed
  );

  modport slave (
    output req, rewind, src_data,
    input  ack, rd_data, rd_eof, busy, src_read, src_reset, words_consumed
  );
endinterface

// File: rtl/input_arbiter.sv
// input_arbiter
//   Shares a sequential input source (read strobe, auto-incrementing address,
//   data one clock after the strobe) between NUM_REQ requesters. One word per
//   transaction, round-robin grant, end-of-input flagged once 2**ADDR_W words
//   have been consumed, and a rewind that restarts the source at word 0.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    input_arbiter_if.master (req/rewind/ack/rd_data/rd_eof/busy,
//            src_read/src_reset/src_data, words_consumed)
//   Optional feature: define INPUT_ARB_PREFETCH_EN to add a one-word prefetch
//   buffer that is filled autonomously while idle, so a granted request can be
//   answered without a source read.
module input_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input_arbiter_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef logic [PW:0]        scan_t;
  typedef logic [NUM_REQ-1:0] reqv_t;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, REWIND} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      rr_ptr, grant_idx, pick;
  scan_t              scan;
  logic               found, latch_grant, eof_nxt, eof_sel, at_depth;
  logic [ADDR_W:0]    words_consumed;
  logic               rewind_pend;
  reqv_t              ack;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_eof;
`ifdef INPUT_ARB_PREFETCH_EN
  logic               pf_valid, pf_txn, start_pf, take_pf;
  logic [DATA_W-1:0]  pf_data;
`endif

  assign at_depth = (words_consumed == DEPTH);

  // Round-robin search: first set req starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + scan_t'(i);
      if (scan >= scan_t'(NUM_REQ)) scan = scan - scan_t'(NUM_REQ);
      if (!found && bus.req[scan[PW-1:0]]) begin
        found = 1'b1;
        pick  = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pending rewind always wins in IDLE so it runs before any new grant.
  always_comb begin
    state_nxt   = state;
    latch_grant = 1'b0;
    eof_nxt     = 1'b0;
`ifdef INPUT_ARB_PREFETCH_EN
    start_pf    = 1'b0;
    take_pf     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rewind_pend || bus.rewind) begin
          state_nxt = REWIND;
        end else if (found) begin
          latch_grant = 1'b1;
`ifdef INPUT_ARB_PREFETCH_EN
          if (pf_valid) begin
            state_nxt = RESP;
            take_pf   = 1'b1;
          end else
`endif
          if (at_depth) begin
            state_nxt = RESP;
            eof_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
`ifdef INPUT_ARB_PREFETCH_EN
        else if (!pf_valid && !at_depth) begin
          state_nxt = ISSUE;
          start_pf  = 1'b1;
        end
`endif
      end
      ISSUE:   state_nxt = CAPTURE;
`ifdef INPUT_ARB_PREFETCH_EN
      CAPTURE: state_nxt = pf_txn ? IDLE : RESP;
`else
      CAPTURE: state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      REWIND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ack/rd_data/rd_eof are registered; ack is raised on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      grant_idx      <= '0;
      eof_sel        <= 1'b0;
      words_consumed <= '0;
      rewind_pend    <= 1'b0;
      ack            <= '0;
      rd_data        <= '0;
      rd_eof         <= 1'b0;
`ifdef INPUT_ARB_PREFETCH_EN
      pf_valid       <= 1'b0;
      pf_txn         <= 1'b0;
      pf_data        <= '0;
`endif
    end else begin
      ack <= '0;
      if (latch_grant) begin
        grant_idx <= pick;
        eof_sel   <= eof_nxt;
      end
`ifdef INPUT_ARB_PREFETCH_EN
      if (state == IDLE) pf_txn <= start_pf;
      if (take_pf) begin
        rd_data  <= pf_data;
        pf_valid <= 1'b0;
      end
`endif
      if (state == ISSUE && !at_depth) words_consumed <= words_consumed + 1'b1;
      if (state == CAPTURE) begin
`ifdef INPUT_ARB_PREFETCH_EN
        if (pf_txn) begin
          pf_data  <= bus.src_data;
          pf_valid <= 1'b1;
        end else
`endif
        rd_data <= bus.src_data;
      end
      if (state == RESP) begin
        ack    <= reqv_t'(1) << grant_idx;
        rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        rd_eof <= eof_sel;
        if (eof_sel) rd_data <= '0;
      end
      // A rewind seen during REWIND itself is absorbed rather than queued.
      if (state == REWIND) begin
        words_consumed <= '0;
        rd_eof         <= 1'b0;
        rewind_pend    <= 1'b0;
`ifdef INPUT_ARB_PREFETCH_EN
        pf_valid       <= 1'b0;
`endif
      end else if (bus.rewind && state != IDLE) begin
        rewind_pend <= 1'b1;
      end
    end
  end

  assign bus.ack            = ack;
  assign bus.rd_data        = rd_data;
  assign bus.rd_eof         = rd_eof;
  assign bus.words_consumed = words_consumed;
  assign bus.busy           = (state != IDLE) || rewind_pend;
  assign bus.src_read       = (state == ISSUE);
  assign bus.src_reset      = reset || (state == REWIND);
endmodule

// File: tb/tb_input_arbiter.sv
// tb_input_arbiter
//   Self-checking bench for input_arbiter (NUM_REQ=2, ADDR_W=3 so the
//   end-of-input boundary is reachable). A behavioural source model serves
//   words from a small memory; a transaction-level reference model (next word
//   index, round-robin pointer, pending request set) predicts every ack.
//   Handles both the default build and INPUT_ARB_PREFETCH_EN.
module tb_input_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  input_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sequential source: address counter, data registered one clock after read.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] src_addr;
  always @(posedge clk) begin
    if (bus.src_reset) begin
      src_addr <= '0;
    end else if (bus.src_read) begin
      bus.src_data <= mem[src_addr];
      src_addr     <= src_addr + 1'b1;
    end
  end

  int checks;
  int errors;
  int next_word;
  int rr;
  logic [NUM_REQ-1:0] pending;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rw);
    bus.req    = r;
    bus.rewind = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(output int edges, output int reads, output bit got);
    edges = 0;
    reads = 0;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      edges++;
      if (bus.src_read) reads++;
      if (bus.ack != '0) got = 1'b1;
    end
  endtask

  // Waits for the next ack and compares it with the reference model, then
  // drops the served request in the ack cycle.
  task automatic serveOne(input string tag, input bit check_timing);
    int g;
    int edges;
    int reads;
    int exp_lat;
    int exp_reads;
    bit got;
    bit exp_eof;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] widx;
    g = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pending[(rr + i) % NUM_REQ]) g = (rr + i) % NUM_REQ;
    exp_eof  = (next_word == DEPTH);
    exp_data = '0;
    if (!exp_eof) begin
      widx     = next_word[ADDR_W-1:0];
      exp_data = mem[widx];
    end
`ifdef INPUT_ARB_PREFETCH_EN
    exp_lat   = 2;
    exp_reads = 0;
`else
    exp_lat   = exp_eof ? 2 : 4;
    exp_reads = exp_eof ? 0 : 1;
`endif
    waitAck(edges, reads, got);
    checkOutput({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (!exp_eof) next_word++;
    if (got) begin
      checkOutput({tag, "_ack"}, 32'(bus.ack), 32'(1 << g));
      checkOutput({tag, "_data"}, 32'(bus.rd_data), 32'(exp_data));
      checkOutput({tag, "_eof"}, 32'(bus.rd_eof), 32'(exp_eof));
      if (check_timing) begin
        checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        checkOutput({tag, "_src_reads"}, 32'(reads), 32'(exp_reads));
      end
`ifndef INPUT_ARB_PREFETCH_EN
      checkOutput({tag, "_words"}, 32'(bus.words_consumed), 32'(next_word));
`endif
    end
    rr = (g + 1) % NUM_REQ;
    pending[g] = 1'b0;
    applyStimulus(pending, 1'b0);
  endtask

  initial begin
    int reads;
    int acks;
    checks    = 0;
    errors    = 0;
    next_word = 0;
    rr        = 0;
    pending   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;

    reset = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_ack", 32'(bus.ack), 32'd0);
    checkOutput("rst_rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("rst_rd_eof", 32'(bus.rd_eof), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_src_read", 32'(bus.src_read), 32'd0);
    checkOutput("rst_src_reset", 32'(bus.src_reset), 32'd1);
    checkOutput("rst_words", 32'(bus.words_consumed), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_src_reset", 32'(bus.src_reset), 32'd0);

`ifndef INPUT_ARB_PREFETCH_EN
    pending = 2'b01;
    applyStimulus(pending, 1'b0);
    serveOne("w0", 1'b1);
    pending = 2'b01;
    applyStimulus(pending, 1'b0);
    serveOne("w1", 1'b1);

    // Rewind pulsed while the source read is being issued.
    pending = 2'b01;
    applyStimulus(pending, 1'b0);
    tick();
    checkOutput("rw_issue_src_read", 32'(bus.src_read), 32'd1);
    applyStimulus(pending, 1'b1);
    tick();
    applyStimulus(pending, 1'b0);
    serveOne("rw_word", 1'b0);
    checkOutput("rw_pending_busy", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("rw_src_reset_on", 32'(bus.src_reset), 32'd1);
    tick();
    checkOutput("rw_src_reset_off", 32'(bus.src_reset), 32'd0);
    checkOutput("rw_words_cleared", 32'(bus.words_consumed), 32'd0);
    checkOutput("rw_idle", 32'(bus.busy), 32'd0);
    next_word = 0;
`else
    // Idle after reset: the buffer fills with exactly one source read.
    reads = 0;
    repeat (5) begin
      tick();
      if (bus.src_read) reads++;
    end
    checkOutput("pf_idle_reads", 32'(reads), 32'd1);
    checkOutput("pf_idle_words", 32'(bus.words_consumed), 32'd1);
    pending = 2'b10;
    applyStimulus(pending, 1'b0);
    serveOne("pf_hit", 1'b1);
`endif

    // Both requesters continuously asking.
    for (int t = 0; t < 4; t++) begin
      pending = 2'b11;
      applyStimulus(pending, 1'b0);
`ifdef INPUT_ARB_PREFETCH_EN
      serveOne("rr", 1'b0);
`else
      serveOne("rr", 1'b1);
`endif
    end

    // Random request patterns, running past the end of input.
    for (int t = 0; t < 12; t++) begin
      pending = pending | NUM_REQ'($urandom);
      if (pending == '0) pending[$urandom_range(NUM_REQ - 1, 0)] = 1'b1;
      applyStimulus(pending, 1'b0);
`ifdef INPUT_ARB_PREFETCH_EN
      serveOne("rnd", 1'b0);
`else
      serveOne("rnd", 1'b1);
`endif
    end
    pending = '0;
    applyStimulus(pending, 1'b0);

    // Rewind from IDLE after end of input.
    applyStimulus('0, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    checkOutput("idle_rw_src_reset", 32'(bus.src_reset), 32'd1);
    tick();
    checkOutput("idle_rw_words", 32'(bus.words_consumed), 32'd0);
    checkOutput("idle_rw_eof_clear", 32'(bus.rd_eof), 32'd0);
    next_word = 0;
    pending = 2'b10;
    applyStimulus(pending, 1'b0);
    serveOne("after_rewind", 1'b0);

`ifndef INPUT_ARB_PREFETCH_EN
    // Reset landing in CAPTURE aborts the transaction with no ack.
    pending = 2'b01;
    applyStimulus(pending, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrst_ack", 32'(bus.ack), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_src_read", 32'(bus.src_read), 32'd0);
    checkOutput("midrst_src_reset", 32'(bus.src_reset), 32'd1);
    checkOutput("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("midrst_rd_eof", 32'(bus.rd_eof), 32'd0);
    checkOutput("midrst_words", 32'(bus.words_consumed), 32'd0);
    pending = '0;
    applyStimulus(pending, 1'b0);
    acks = 0;
    tick();
    if (bus.ack != '0) acks++;
    reset = 1'b0;
    repeat (3) begin
      tick();
      if (bus.ack != '0) acks++;
    end
    checkOutput("midrst_no_ack", 32'(acks), 32'd0);
    next_word = 0;
    rr = 0;
    pending = 2'b10;
    applyStimulus(pending, 1'b0);
    serveOne("post_reset", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
